multicycle_dispatcher: RTL and testbench

//  Initiator for the multicycle opcode unit. Accepts an 8-bit multicycle instruction from the main decoder and reads

---
 rtl/multicycle_dispatcher_if.sv | 40 ++++
 rtl/multicycle_dispatcher.sv | 123 ++++++++++++
 tb/tb_multicycle_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_dispatcher_if.sv
// Handshake and data bundle between the dispatcher, the main decoder/register file
// and the multicycle opcode unit.
interface multicycle_dispatcher_if;
    logic       run;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic [7:0] reg_a;
    logic [7:0] reg_b;
    logic [7:0] reg_c;
    logic [7:0] reg_d;
    logic [7:0] output_to_multicycle_opcode;
    logic [7:0] mc_op_x;
    logic [7:0] mc_op_y;
    logic       mc_start;
    logic       opcode_next_instruction_trigger;
    logic [7:0] output_from_multicycle_opcode;
    logic       stall;
    logic       wb_en;
    logic [1:0] wb_sel;
    logic [7:0] wb_data;
    logic       error;
    logic [1:0] error_code;

    // Dispatcher side
    modport master (
        input  run, instr_valid, instr, reg_a, reg_b, reg_c, reg_d,
               opcode_next_instruction_trigger, output_from_multicycle_opcode,
        output instr_ready, output_to_multicycle_opcode, mc_op_x, mc_op_y, mc_start,
               stall, wb_en, wb_sel, wb_data, error, error_code
    );

    // Decoder / register file / opcode unit side
    modport slave (
        output run, instr_valid, instr, reg_a, reg_b, reg_c, reg_d,
               opcode_next_instruction_trigger, output_from_multicycle_opcode,
        input  instr_ready, output_to_multicycle_opcode, mc_op_x, mc_op_y, mc_start,
               stall, wb_en, wb_sel, wb_data, error, error_code
    );
endinterface

// File: rtl/multicycle_dispatcher.sv
// Issues multicycle instructions to the opcode unit, stalls the CPU while the op is in
// flight, and writes the result back to registers A-D.
module multicycle_dispatcher #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic clock,
    input logic reset,
    multicycle_dispatcher_if.master bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [7:0]       instr_q, op_x_q, op_y_q, wb_data_q;
    logic [1:0]       wb_sel_q, err_code_q;
    logic             err_q;

    logic [3:0] op;
    logic [7:0] sel_x, sel_y;
    logic       accept, op_illegal, op_div0, timed_out, result_in;

    function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a, b, c, d);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        timed_out  = 1'b0;
        result_in  = 1'b0;
        op         = bus.instr[7:4];
        // RAND carries its bound in the low nibble instead of register selects
        sel_x      = (op == 4'd5) ? '0 : pick(bus.instr[3:2], bus.reg_a, bus.reg_b, bus.reg_c, bus.reg_d);
        sel_y      = (op == 4'd5) ? {4'b0, bus.instr[3:0]}
                                  : pick(bus.instr[1:0], bus.reg_a, bus.reg_b, bus.reg_c, bus.reg_d);
        op_illegal = (op == 4'd0) || (op >= 4'd6);
        op_div0    = ((op == 4'd3) || (op == 4'd4)) && (sel_y == '0);
        case (state)
            IDLE: begin
                accept = bus.run & bus.instr_valid;
                if (accept && !op_illegal && !op_div0)
                    state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (bus.opcode_next_instruction_trigger) begin
                    result_in = 1'b1;
                    state_nxt = WB;
                end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt   <= '0;
            instr_q    <= '0;
            op_x_q     <= '0;
            op_y_q     <= '0;
            wb_data_q  <= '0;
            wb_sel_q   <= '0;
            err_code_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                instr_q <= bus.instr;
                op_x_q  <= sel_x;
                op_y_q  <= sel_y;
                if (op_illegal) begin
                    err_q      <= 1'b1;
                    err_code_q <= 2'b01;
                end else if (op_div0) begin
                    err_q      <= 1'b1;
                    err_code_q <= 2'b10;
                end
            end
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (timed_out) begin
                err_q      <= 1'b1;
                err_code_q <= 2'b11;
            end
            if (result_in) begin
                wb_data_q <= bus.output_from_multicycle_opcode;
                wb_sel_q  <= (instr_q[7:4] == 4'd5) ? 2'b00 : instr_q[3:2];
            end
        end
    end

    assign bus.instr_ready                 = (state == IDLE);
    assign bus.stall                       = (state != IDLE);
    assign bus.mc_start                    = (state == ISSUE);
    assign bus.wb_en                       = (state == WB);
    assign bus.output_to_multicycle_opcode = instr_q;
    assign bus.mc_op_x                     = op_x_q;
    assign bus.mc_op_y                     = op_y_q;
    assign bus.wb_sel                      = wb_sel_q;
    assign bus.wb_data                     = wb_data_q;
    assign bus.error                       = err_q;
    assign bus.error_code                  = err_code_q;
endmodule

// File: tb/tb_multicycle_dispatcher.sv
// Bench for multicycle_dispatcher: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_multicycle_dispatcher;
    localparam int unsigned TMO = 8;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_dispatcher_if bif ();

    multicycle_dispatcher #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    function automatic logic [7:0] rd(input logic [1:0] s);
        case (s)
            2'd0:    return bif.reg_a;
            2'd1:    return bif.reg_b;
            2'd2:    return bif.reg_c;
            default: return bif.reg_d;
        endcase
    endfunction

    // Model: one in-flight op tracked by its age since acceptance
    bit          m_on, m_busy, m_have, m_err;
    int unsigned m_age;
    logic [7:0]  m_instr, m_x, m_y, m_wbdata;
    logic [1:0]  m_wbsel, m_code;

    always @(posedge clock) begin : model
        logic [3:0] op;
        logic [7:0] x, y;
        m_err <= 1'b0;
        if (!reset) begin
            m_on    <= 1'b1;
            m_busy  <= 1'b0;
            m_have  <= 1'b0;
            m_age   <= 0;
            m_instr <= '0;
            m_x     <= '0;
            m_y     <= '0;
            m_code  <= '0;
        end else if (!m_busy) begin
            if (bif.run && bif.instr_valid) begin
                op = bif.instr[7:4];
                x  = (op == 4'd5) ? 8'd0 : rd(bif.instr[3:2]);
                y  = (op == 4'd5) ? {4'h0, bif.instr[3:0]} : rd(bif.instr[1:0]);
                m_instr <= bif.instr;
                m_x     <= x;
                m_y     <= y;
                if (op == 4'd0 || op > 4'd5) begin
                    m_err  <= 1'b1;
                    m_code <= 2'b01;
                end else if ((op == 4'd3 || op == 4'd4) && y == 8'd0) begin
                    m_err  <= 1'b1;
                    m_code <= 2'b10;
                end else begin
                    m_busy <= 1'b1;
                    m_age  <= 1;
                    m_have <= 1'b0;
                end
            end
        end else if (m_have) begin
            m_busy <= 1'b0;
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (bif.opcode_next_instruction_trigger) begin
            m_have   <= 1'b1;
            m_wbdata <= bif.output_from_multicycle_opcode;
            m_wbsel  <= (m_instr[7:4] == 4'd5) ? 2'b00 : m_instr[3:2];
        end else if (m_age - 1 == TMO) begin
            m_busy <= 1'b0;
            m_err  <= 1'b1;
            m_code <= 2'b11;
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clock) begin
        if (m_on) begin
            chk("stall",       bif.stall,                       m_busy);
            chk("instr_ready", bif.instr_ready,                 !m_busy);
            chk("mc_start",    bif.mc_start,                    m_busy && m_age == 1);
            chk("wb_en",       bif.wb_en,                       m_busy && m_have);
            chk("error",       bif.error,                       m_err);
            chk("error_code",  bif.error_code,                  m_code);
            chk("opcode_out",  bif.output_to_multicycle_opcode, m_instr);
            chk("mc_op_x",     bif.mc_op_x,                     m_x);
            chk("mc_op_y",     bif.mc_op_y,                     m_y);
            if (m_busy && m_have) begin
                chk("wb_sel",  bif.wb_sel,  m_wbsel);
                chk("wb_data", bif.wb_data, m_wbdata);
            end
        end
    end

    initial begin
        int stall_cnt;
        bit wb_any;
        logic [3:0] op;
        reset = 1'b0;
        bif.run = 1'b1;
        bif.instr_valid = 1'b0;
        bif.instr = '0;
        bif.reg_a = '0;
        bif.reg_b = '0;
        bif.reg_c = '0;
        bif.reg_d = '0;
        bif.opcode_next_instruction_trigger = 1'b0;
        bif.output_from_multicycle_opcode = '0;

        // Reset state
        cyc();
        cyc();
        smp();
        chk("rst_stall", bif.stall, 1'b0);
        chk("rst_wb_en", bif.wb_en, 1'b0);
        chk("rst_error", bif.error, 1'b0);
        chk("rst_ready", bif.instr_ready, 1'b1);
        chk("rst_start", bif.mc_start, 1'b0);

        // GCD B,D with fastest possible completion
        cyc();
        reset = 1'b1;
        bif.reg_a = 8'h11; bif.reg_b = 8'd12; bif.reg_c = 8'h33; bif.reg_d = 8'd18;
        bif.instr = 8'h17; bif.instr_valid = 1'b1;
        cyc();
        bif.instr_valid = 1'b0;
        bif.reg_b = 8'hFF;
        smp();
        chk("gcd_start", bif.mc_start, 1'b1);
        chk("gcd_x", bif.mc_op_x, 8'd12);
        chk("gcd_y", bif.mc_op_y, 8'd18);
        stall_cnt = int'(bif.stall);
        cyc();
        bif.opcode_next_instruction_trigger = 1'b1;
        bif.output_from_multicycle_opcode = 8'd6;
        smp();
        chk("gcd_start_once", bif.mc_start, 1'b0);
        stall_cnt += int'(bif.stall);
        cyc();
        bif.opcode_next_instruction_trigger = 1'b0;
        smp();
        chk("gcd_wb_en", bif.wb_en, 1'b1);
        chk("gcd_wb_sel", bif.wb_sel, 2'b01);
        chk("gcd_wb_data", bif.wb_data, 8'd6);
        stall_cnt += int'(bif.stall);
        cyc();
        smp();
        stall_cnt += int'(bif.stall);
        chk("gcd_ready_back", bif.instr_ready, 1'b1);
        chk("gcd_stall_cycles", stall_cnt, 3);

        // Divide by zero, then illegal op
        cyc();
        bif.reg_b = 8'd12; bif.reg_c = 8'd0;
        bif.instr = 8'h3E; bif.instr_valid = 1'b1;
        cyc();
        bif.instr_valid = 1'b0;
        smp();
        chk("div0_error", bif.error, 1'b1);
        chk("div0_code", bif.error_code, 2'b10);
        chk("div0_stall", bif.stall, 1'b0);
        chk("div0_start", bif.mc_start, 1'b0);
        cyc();
        bif.instr = 8'h70; bif.instr_valid = 1'b1;
        cyc();
        bif.instr_valid = 1'b0;
        smp();
        chk("illegal_error", bif.error, 1'b1);
        chk("illegal_code", bif.error_code, 2'b01);

        // MUL with no response -> timeout after TMO wait cycles
        cyc();
        bif.reg_a = 8'd3; bif.reg_b = 8'd5;
        bif.instr = 8'h25; bif.instr_valid = 1'b1;
        cyc();
        bif.instr_valid = 1'b0;
        wb_any = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            smp();
            wb_any |= bif.wb_en;
            if (i == 9) chk("tmo_stall_last", bif.stall, 1'b1);
            if (i == 10) begin
                chk("tmo_error", bif.error, 1'b1);
                chk("tmo_code", bif.error_code, 2'b11);
                chk("tmo_ready", bif.instr_ready, 1'b1);
            end
            cyc();
        end
        chk("tmo_no_wb", wb_any, 1'b0);

        // RAND with bound 0xA, result lands in A
        bif.reg_a = 8'd99;
        bif.instr = 8'h5A; bif.instr_valid = 1'b1;
        cyc();
        bif.instr_valid = 1'b0;
        smp();
        chk("rand_x", bif.mc_op_x, 8'h00);
        chk("rand_y", bif.mc_op_y, 8'h0A);
        cyc();
        bif.opcode_next_instruction_trigger = 1'b1;
        bif.output_from_multicycle_opcode = 8'd7;
        cyc();
        bif.opcode_next_instruction_trigger = 1'b0;
        smp();
        chk("rand_wb_en", bif.wb_en, 1'b1);
        chk("rand_wb_sel", bif.wb_sel, 2'b00);
        chk("rand_wb_data", bif.wb_data, 8'd7);
        cyc();
        bif.run = 1'b0;
        bif.instr = 8'h17; bif.instr_valid = 1'b1;
        repeat (3) cyc();
        smp();
        chk("norun_stall", bif.stall, 1'b0);
        chk("norun_opcode", bif.output_to_multicycle_opcode, 8'h5A);
        cyc();
        bif.run = 1'b1;
        bif.instr_valid = 1'b0;

        // Reset during WAIT, late trigger, trigger while idle
        bif.reg_b = 8'd12; bif.reg_d = 8'd18;
        bif.instr = 8'h17; bif.instr_valid = 1'b1;
        cyc();
        bif.instr_valid = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        bif.opcode_next_instruction_trigger = 1'b1;
        bif.output_from_multicycle_opcode = 8'd9;
        cyc();
        bif.opcode_next_instruction_trigger = 1'b0;
        smp();
        chk("abort_wb_en", bif.wb_en, 1'b0);
        chk("abort_stall", bif.stall, 1'b0);
        cyc();
        bif.opcode_next_instruction_trigger = 1'b1;
        cyc();
        bif.opcode_next_instruction_trigger = 1'b0;
        smp();
        chk("idle_trig_stall", bif.stall, 1'b0);
        chk("idle_trig_wb", bif.wb_en, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc();
            reset = ($urandom_range(0, 63) != 0);
            bif.run = ($urandom_range(0, 7) != 0);
            bif.instr_valid = $urandom_range(0, 1);
            if ($urandom_range(0, 9) < 8) op = 4'($urandom_range(1, 5));
            else op = 4'($urandom_range(6, 16));
            bif.instr = {op, 4'($urandom_range(0, 15))};
            bif.reg_a = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            bif.reg_b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            bif.reg_c = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            bif.reg_d = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            bif.opcode_next_instruction_trigger = ($urandom_range(0, 3) == 0);
            bif.output_from_multicycle_opcode = 8'($urandom);
        end
        cyc();
        smp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
